// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// Pops a commanded burst of words from a synchronous FIFO (1-cycle read
// latency) and presents them on a valid/ready stream. A 3-entry output
// buffer absorbs the read latency so the burst can run at one word per clock.
// The FIFO read enable depends only on registered state and the FIFO empty
// flag, never on the downstream ready.

module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 12,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] BUF_DEPTH = 3'd3;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;

  // Words still to be requested from the FIFO and words still to be
  // handed to the sink.
  logic [LEN_WIDTH-1:0]  rd_left;
  logic [LEN_WIDTH-1:0]  tx_left;

  // Output buffer: entry 0 is always the head of the stream.
  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [DATA_WIDTH-1:0] buf_nxt [3];
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic [1:0]            wr_idx;

  // A FIFO read was issued last cycle; its data is on fifo_rdata_i now.
  logic                  inflight;

  logic [2:0]            occupancy;
  logic                  issue;
  logic                  pop;
  logic                  capture;
  logic                  start_ok;

  // Buffer slots already committed: stored words plus the one in flight.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};

  // Read only when a slot is guaranteed free for the returning word, so the
  // decision never has to look at the sink's ready.
  assign issue    = (state == RUN) && !fifo_empty_i && (rd_left != '0)
                    && (occupancy < BUF_DEPTH);
  assign pop      = (buf_cnt != 2'd0) && m_ready_i;
  assign capture  = inflight;
  assign start_ok = (state == IDLE) && start_i;

  assign fifo_rd_en_o = issue;
  assign m_valid_o    = (buf_cnt != 2'd0);
  assign m_data_o     = buf_mem[0];
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // Next buffer contents: shift on pop, then write the returning word into
  // the first free slot after the shift.
  always_comb begin
    buf_nxt = buf_mem;
    wr_idx  = pop ? (buf_cnt - 2'd1) : buf_cnt;
    if (pop) begin
      buf_nxt[0] = buf_mem[1];
      buf_nxt[1] = buf_mem[2];
      buf_nxt[2] = '0;
    end
    if (capture) begin
      case (wr_idx)
        2'd0:    buf_nxt[0] = fifo_rdata_i;
        2'd1:    buf_nxt[1] = fifo_rdata_i;
        2'd2:    buf_nxt[2] = fifo_rdata_i;
        default: ;
      endcase
    end
  end

  // Occupancy bookkeeping; a simultaneous pop and capture cancel out.
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    case ({pop, capture})
      2'b10:   buf_cnt_nxt = buf_cnt - 2'd1;
      2'b01:   buf_cnt_nxt = buf_cnt + 2'd1;
      default: buf_cnt_nxt = buf_cnt;
    endcase
  end

  // Buffer storage, occupancy and the in-flight read flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_mem[2] <= '0;
      buf_cnt    <= 2'd0;
      inflight   <= 1'b0;
    end else begin
      buf_mem  <= buf_nxt;
      buf_cnt  <= buf_cnt_nxt;
      inflight <= issue;
    end
  end

  // Burst counters: loaded on an accepted start, counted down by reads
  // issued and by words delivered, saturating at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_left <= '0;
      tx_left <= '0;
    end else if (start_ok) begin
      rd_left <= len_i;
      tx_left <= len_i;
    end else begin
      if (issue && (rd_left != '0)) begin
        rd_left <= rd_left - 1'b1;
      end
      if (pop && (tx_left != '0)) begin
        tx_left <= tx_left - 1'b1;
      end
    end
  end

  // Burst sequencing with registered busy and done flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (rd_left == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (tx_left == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
